// File: rtl/btn_cmd_ctrl.sv
// Pushbutton front end: synchronize and debounce three active-low buttons, then
// emit press/release/auto-repeat strobes plus a latched mode code and step strobe.
module btn_cmd_ctrl #(
  parameter int CLOCK_MHZ       = 50,
  parameter int US_PER_MS       = 1000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       swch1,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       btn2,
  output logic [2:0] btn_state,
  output logic [2:0] press_pulse,
  output logic [2:0] release_pulse,
  output logic [2:0] repeat_pulse,
  output logic [1:0] mode,
  output logic       step
);

  localparam int US_W   = $clog2(CLOCK_MHZ + 1);
  localparam int MS_W   = $clog2(US_PER_MS + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY_MS + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE_MS + 1);

  typedef enum logic [1:0] {RELEASED, PRESS_DEB, PRESSED, RELEASE_DEB} deb_state_t;

  logic [US_W-1:0] us_cnt_reg;
  logic [MS_W-1:0] ms_cnt_reg;
  logic            us_tick_reg;
  logic            ms_tick_reg;
  logic [2:0]      sync1_reg;
  logic [2:0]      sync2_reg;
  logic [1:0]      mode_reg;
  logic [1:0]      mode_next;
  logic            step_reg;
  logic            step_next;
  logic [2:0]      mode_sel;

  always_ff @(posedge clk) begin
    if (swch1) begin
      us_cnt_reg  <= '0;
      ms_cnt_reg  <= '0;
      us_tick_reg <= 1'b0;
      ms_tick_reg <= 1'b0;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
    end else begin
      us_tick_reg <= 1'b0;
      ms_tick_reg <= 1'b0;
      if (us_cnt_reg == US_W'(CLOCK_MHZ - 1)) begin
        us_cnt_reg  <= '0;
        us_tick_reg <= 1'b1;
      end else begin
        us_cnt_reg <= us_cnt_reg + US_W'(1);
      end
      if (us_tick_reg) begin
        if (ms_cnt_reg == MS_W'(US_PER_MS - 1)) begin
          ms_cnt_reg  <= '0;
          ms_tick_reg <= 1'b1;
        end else begin
          ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
        end
      end
      sync1_reg <= ~{btn2, btn1, btn0};
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      deb_state_t        state_reg, state_next;
      logic [7:0]        deb_cnt_reg, deb_cnt_next;
      logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
      logic [RATE_W-1:0] rate_cnt_reg, rate_cnt_next;
      logic              press_reg, press_next;
      logic              release_reg, release_next;
      logic              repeat_reg, repeat_next;
      logic              sync;

      assign sync = sync2_reg[gi];

      always_comb begin
        state_next    = state_reg;
        deb_cnt_next  = deb_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        rate_cnt_next = rate_cnt_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        repeat_next   = 1'b0;
        case (state_reg)
          RELEASED: begin
            if (sync) begin
              state_next   = PRESS_DEB;
              deb_cnt_next = '0;
            end
          end
          PRESS_DEB: begin
            if (!sync) begin
              state_next = RELEASED;
            end else if (ms_tick_reg) begin
              if (deb_cnt_reg == 8'(DEBOUNCE_MS - 1)) begin
                state_next    = PRESSED;
                press_next    = 1'b1;
                hold_cnt_next = '0;
                rate_cnt_next = '0;
              end else begin
                deb_cnt_next = deb_cnt_reg + 8'd1;
              end
            end
          end
          PRESSED: begin
            if (!sync) begin
              state_next   = RELEASE_DEB;
              deb_cnt_next = '0;
            end else if (ms_tick_reg) begin
              // hold_cnt parks at the delay; rate_cnt then paces the repeats
              if (hold_cnt_reg != HOLD_W'(REPEAT_DELAY_MS)) begin
                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                repeat_next   = (hold_cnt_reg == HOLD_W'(REPEAT_DELAY_MS - 1));
              end else if (rate_cnt_reg == RATE_W'(REPEAT_RATE_MS - 1)) begin
                rate_cnt_next = '0;
                repeat_next   = 1'b1;
              end else begin
                rate_cnt_next = rate_cnt_reg + RATE_W'(1);
              end
            end
          end
          RELEASE_DEB: begin
            if (sync) begin
              state_next = PRESSED;
            end else if (ms_tick_reg) begin
              if (deb_cnt_reg == 8'(DEBOUNCE_MS - 1)) begin
                state_next   = RELEASED;
                release_next = 1'b1;
              end else begin
                deb_cnt_next = deb_cnt_reg + 8'd1;
              end
            end
          end
          default: state_next = RELEASED;
        endcase
      end

      always_ff @(posedge clk) begin
        if (swch1) begin
          state_reg    <= RELEASED;
          deb_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
          rate_cnt_reg <= '0;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          repeat_reg   <= 1'b0;
        end else begin
          state_reg    <= state_next;
          deb_cnt_reg  <= deb_cnt_next;
          hold_cnt_reg <= hold_cnt_next;
          rate_cnt_reg <= rate_cnt_next;
          press_reg    <= press_next;
          release_reg  <= release_next;
          repeat_reg   <= repeat_next;
        end
      end

      assign btn_state[gi]     = (state_reg == PRESSED) || (state_reg == RELEASE_DEB);
      assign press_pulse[gi]   = press_reg;
      assign release_pulse[gi] = release_reg;
      assign repeat_pulse[gi]  = repeat_reg;
    end
  endgenerate

  // Lowest-numbered button wins when several presses land together
  always_comb begin
    mode_next = mode_reg;
    if (press_pulse[0])      mode_next = 2'd1;
    else if (press_pulse[1]) mode_next = 2'd2;
    else if (press_pulse[2]) mode_next = 2'd3;
    mode_sel  = {mode_next == 2'd3, mode_next == 2'd2, mode_next == 2'd1};
    step_next = |((press_pulse | repeat_pulse) & mode_sel);
  end

  always_ff @(posedge clk) begin
    if (swch1) begin
      mode_reg <= 2'd0;
      step_reg <= 1'b0;
    end else begin
      mode_reg <= mode_next;
      step_reg <= step_next;
    end
  end

  assign mode = mode_reg;
  assign step = step_reg;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Scoreboard bench for btn_cmd_ctrl at reduced timing (1 ms = 8 clocks):
// stimulus queues expected strobes, a negedge monitor pops and compares them.
module tb_btn_cmd_ctrl;

  logic       clk = 1'b0;
  logic       swch1, btn0, btn1, btn2;
  logic [2:0] btn_state, press_pulse, release_pulse, repeat_pulse;
  logic [1:0] mode;
  logic       step;

  btn_cmd_ctrl #(
    .CLOCK_MHZ(2), .US_PER_MS(4), .DEBOUNCE_MS(3),
    .REPEAT_DELAY_MS(6), .REPEAT_RATE_MS(2)
  ) dut (
    .clk(clk), .swch1(swch1), .btn0(btn0), .btn1(btn1), .btn2(btn2),
    .btn_state(btn_state), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .mode(mode), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [2:0] val;
    int         lo;
    int         hi;
    bit         rel;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;
  int   last_press_cyc = 0;
  int   m_mode = 0;
  bit   exp_step = 0;
  bit   chk_mode = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= swch1;
  end

  function automatic string kname(input int k);
    if (k == 0) return "press";
    if (k == 1) return "release";
    return "repeat";
  endfunction

  task automatic check_ev(input int kind, input logic [2:0] v);
    ev_t e;
    int  rc;
    if (v != 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_%s: got val=%b at cyc=%0d, required no strobe", kname(kind), v, cyc);
      end else begin
        e  = exp_q.pop_front();
        rc = e.rel ? cyc - last_press_cyc : cyc;
        if (e.kind != kind || e.val != v || rc < e.lo || rc > e.hi) begin
          bad++;
          $display("FAIL %s_event: got %s val=%b t=%0d, required %s val=%b t=%0d..%0d",
                   kname(e.kind), kname(kind), v, rc, kname(e.kind), e.val, e.lo, e.hi);
        end else begin
          $display("ok %s val=%b t=%0d", kname(kind), v, rc);
        end
      end
      if (kind == 0) last_press_cyc = cyc;
    end
  endtask

  // Monitor: strobes via the queue, mode/step via a small reference model
  always @(negedge clk) begin
    if (rst_q) begin
      total++;
      if ({btn_state, press_pulse, release_pulse, repeat_pulse, mode, step} !== 15'd0) begin
        bad++;
        $display("FAIL reset_outputs: got state=%b pr=%b rl=%b rp=%b mode=%0d step=%b, required all 0",
                 btn_state, press_pulse, release_pulse, repeat_pulse, mode, step);
      end
      m_mode = 0; exp_step = 0; chk_mode = 0;
    end else begin
      if (exp_step || step) begin
        total++;
        if (step !== exp_step) begin
          bad++;
          $display("FAIL step: got %b at cyc=%0d, required %b", step, cyc, exp_step);
        end
      end
      if (chk_mode) begin
        total++;
        if (mode !== 2'(m_mode)) begin
          bad++;
          $display("FAIL mode: got %0d at cyc=%0d, required %0d", mode, cyc, m_mode);
        end
      end
      check_ev(0, press_pulse);
      check_ev(1, release_pulse);
      check_ev(2, repeat_pulse);
      chk_mode = |press_pulse;
      if (press_pulse[0])      m_mode = 1;
      else if (press_pulse[1]) m_mode = 2;
      else if (press_pulse[2]) m_mode = 3;
      exp_step = (m_mode != 0) && ((press_pulse[m_mode-1] | repeat_pulse[m_mode-1]) == 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [2:0] v, input int lo, input int hi, input bit rel);
    ev_t e;
    e.kind = kind; e.val = v; e.lo = lo; e.hi = hi; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input int b, input logic lvl);
    int k = 0;
    while (btn_state[b] !== lvl && k < 200) begin
      idle(1);
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_btn_state%0d: got %b after 200 cycles, required %b", b, btn_state[b], lvl);
    end
  endtask

  task automatic expect_val(input string nm, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, required %b", nm, got, want);
    end else begin
      $display("ok %s = %b", nm, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    swch1 = 1'b1; btn0 = 1'b1; btn1 = 1'b1; btn2 = 1'b1;
    idle(4);
    swch1 = 1'b0;
    idle(16);

    // Clean press and release of btn1
    s = cyc; btn1 = 1'b0;
    push(0, 3'b010, s + 19, s + 27, 0);
    wait_state(1, 1'b1);
    expect_val("clean_btn_state", btn_state, 3'b010);
    idle(10);
    s = cyc; btn1 = 1'b1;
    push(1, 3'b010, s + 19, s + 27, 0);
    wait_state(1, 1'b0);
    idle(20);

    // Bounce on btn0: low stretches of 5 cycles are shorter than 1 ms
    for (int i = 0; i < 12; i++) begin
      btn0 = ~btn0;
      idle(5);
      expect_val("bounce_btn_state", btn_state, 3'b000);
    end
    idle(30);
    expect_val("bounce_mode_kept", {1'b0, mode}, 3'd2);

    // Auto-repeat on btn2: first repeat 48 after press, then every 16
    s = cyc; btn2 = 1'b0;
    push(0, 3'b100, s + 19, s + 27, 0);
    for (int r = 0; r < 4; r++) push(2, 3'b100, 48 + 16 * r, 48 + 16 * r, 1);
    wait_state(2, 1'b1);
    idle(100);
    s = cyc; btn2 = 1'b1;
    push(1, 3'b100, s + 19, s + 27, 0);
    wait_state(2, 1'b0);
    idle(30);

    // Simultaneous btn0 + btn2
    s = cyc; btn0 = 1'b0; btn2 = 1'b0;
    push(0, 3'b101, s + 19, s + 27, 0);
    wait_state(0, 1'b1);
    expect_val("simul_btn_state", btn_state, 3'b101);
    idle(3);
    expect_val("simul_mode", {1'b0, mode}, 3'd1);
    idle(7);
    s = cyc; btn0 = 1'b1; btn2 = 1'b1;
    push(1, 3'b101, s + 19, s + 27, 0);
    wait_state(0, 1'b0);
    idle(20);

    // Reset while btn1 is held: must re-debounce into a fresh press
    s = cyc; btn1 = 1'b0;
    push(0, 3'b010, s + 19, s + 27, 0);
    wait_state(1, 1'b1);
    idle(2);
    swch1 = 1'b1;
    idle(3);
    swch1 = 1'b0;
    expect_val("reset_btn_state", btn_state, 3'b000);
    s = cyc;
    push(0, 3'b010, s + 1, s + 27, 0);
    wait_state(1, 1'b1);
    idle(2);
    expect_val("reset_mode", {1'b0, mode}, 3'd2);
    s = cyc; btn1 = 1'b1;
    push(1, 3'b010, s + 19, s + 27, 0);
    wait_state(1, 1'b0);
    idle(30);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d still queued, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cmd_ctrl.md
# btn_cmd_ctrl

Input-side companion to the segment-pattern animator. It synchronizes and debounces the three active-low board pushbuttons, then emits clean press, release and auto-repeat strobes. It also holds a latched mode code naming the last pressed button. The animator consumes `mode` and `step` instead of sampling raw buttons.

## Interface
- `CLOCK_MHZ`, 50: clock frequency in MHz; sets the 1 µs tick divider.
- `US_PER_MS`, 1000: µs ticks per ms tick; reduced only for simulation.
- `DEBOUNCE_MS`, 10: ms a synchronized level must stay stable before it is accepted; range 2..255.
- `REPEAT_DELAY_MS`, 500: ms from accepted press to the first repeat strobe.
- `REPEAT_RATE_MS`, 100: ms between subsequent repeat strobes.
- `clk` input 1: system clock.
- `swch1` input 1: reset, synchronous and active-high.
- `btn0`, `btn1`, `btn2` input 1 each: raw pushbuttons, active-low, asynchronous to `clk`.
- `btn_state` output 3: debounced level per button, 1 = pressed; bit0 = `btn0`.
- `press_pulse` output 3: one-cycle strobe per button when a press is accepted.
- `release_pulse` output 3: one-cycle strobe per button when a release is accepted.
- `repeat_pulse` output 3: one-cycle auto-repeat strobe per held button.
- `mode` output 2: last accepted press; 0 = none, 1 = `btn0`, 2 = `btn1`, 3 = `btn2`.
- `step` output 1: one-cycle strobe when the button named by `mode` produces a press or a repeat.

## Operation
- Time base:
  - A µs counter asserts `us_tick` for one cycle every `CLOCK_MHZ` clocks.
  - A ms counter asserts `ms_tick` for one cycle every `US_PER_MS` µs ticks.
  - Both counters free-run, are cleared by reset, and assert their first tick a full period after reset.
- Synchronizer: each button is inverted and passed through two flops to give `sync[i]`, where 1 = pressed.
- Per-button debounce FSM, with states `RELEASED`, `PRESS_DEB`, `PRESSED` and `RELEASE_DEB`:
  - `RELEASED`: `sync=1` moves to `PRESS_DEB` and clears `deb_cnt`.
  - `PRESS_DEB`:
    - `sync=0` in any cycle returns to `RELEASED`.
    - Each `ms_tick` increments `deb_cnt`.
    - If `ms_tick` arrives with `deb_cnt == DEBOUNCE_MS-1`, the FSM goes to `PRESSED`, pulses `press_pulse[i]` and clears `hold_cnt`.
  - `PRESSED`:
    - `sync=0` moves to `RELEASE_DEB` and clears `deb_cnt`.
    - Each `ms_tick` increments `hold_cnt`.
    - `repeat_pulse[i]` fires on the `ms_tick` where `hold_cnt` reaches `REPEAT_DELAY_MS`, then on every further `REPEAT_RATE_MS`.
    - `hold_cnt` saturates its phase counter and never wraps into a spurious pulse.
  - `RELEASE_DEB`: mirrors `PRESS_DEB`. Acceptance gives `RELEASED` and `release_pulse[i]`; `sync=1` returns to `PRESSED` with `hold_cnt` preserved.
- `btn_state[i]` = 1 in `PRESSED` and `RELEASE_DEB`.
- Mode latch:
  - On any `press_pulse`, `mode` takes that button's code on the next edge.
  - When presses are accepted in the same cycle, priority is `btn0` > `btn1` > `btn2`.
  - Releases do not change `mode`.
- `step` = (`press_pulse` | `repeat_pulse`) of the button selected by the new `mode` value, registered.

## Timing
- Reset values:
  - Every output is 0 and `mode` = 0.
  - All FSMs are in `RELEASED`; all counters and synchronizer flops are 0.
- Reset overrides everything in the same edge. A button still held after reset deasserts must re-debounce and produce a fresh `press_pulse`.
- Pulses (`press_pulse`, `release_pulse`, `repeat_pulse`) are registered, assert for exactly one cycle, and align with the `btn_state` change for press and release.
- `mode` and `step` update one cycle after the pulse that causes them.
- Acceptance latency from a stable input edge:
  - 2 sync cycles, plus (`DEBOUNCE_MS`-1) to `DEBOUNCE_MS` ms of tick phase, plus 1 cycle.
  - The FSM counts whole `ms_tick`s; because of tick phase, the accepted ms count is `DEBOUNCE_MS`-1 full periods plus a partial one.
- A glitch shorter than one ms period never produces a pulse.
- Independent buttons are fully concurrent; simultaneous presses pulse all affected `press_pulse` bits in the same cycle.

## Test plan
- Simulation parameters: `CLOCK_MHZ`=2, `US_PER_MS`=4, `DEBOUNCE_MS`=3, `REPEAT_DELAY_MS`=6, `REPEAT_RATE_MS`=2. With these, 1 ms = 8 clocks.
- Clean press: `btn1` low from cycle 20 and held →
  - `press_pulse`=3'b010 for one cycle 19..27 cycles later;
  - `mode`=2 and `step`=1 one cycle after that;
  - `btn_state`=3'b010.
- Bounce: `btn0` toggles every 5 cycles for 60 cycles, then stays high → no `press_pulse`, `btn_state` stays 0.
- Auto-repeat: hold `btn2` for 120 cycles →
  - one press;
  - first `repeat_pulse[2]` 48 cycles after the press, then every 16 cycles;
  - `step` follows each press and repeat strobe;
  - on release, `release_pulse[2]` fires about 24 cycles after release with no further repeats.
- Simultaneous: `btn0` and `btn2` go low in the same cycle → `press_pulse`=3'b101 in one cycle; `mode`=1.
- Reset mid-hold: hold `btn1` until `btn_state[1]`=1, assert `swch1` for 3 cycles →
  - all outputs 0 during reset;
  - after reset, a new `press_pulse[1]` within 24+3 cycles; `mode`=2.
